// File: rtl/csi_pixel_packer.sv
// csi_pixel_packer
//
// Packs RAW8 CSI-2 payload bytes into 32-bit words for port A of the frame
// RAM. Pixel N of the active window lands at word N>>2, byte lane N[1:0], so
// the display side can address pixels directly. The block crops each line to
// H_ACTIVE pixels and each frame to V_ACTIVE lines. Short lines get their
// last partial word written with zero padding. Framing errors are flagged.
//
// Optional feature: define CSI_PACKER_PINGPONG_EN for double buffering.
// adress_out then gains a bank MSB that toggles on every frame_done, and
// rd_bank reports the most recently completed bank.
//
// Ports:
//   sys_clk      single clock (receiver byte-domain clock)
//   reset        synchronous, active-high reset
//   byte_in      payload pixel byte, qualified by byte_valid
//   byte_valid   byte_in valid this cycle
//   frame_start  one-cycle pulse, Frame Start short packet
//   frame_end    one-cycle pulse, Frame End short packet
//   line_start   one-cycle pulse, start of a long packet
//   line_end     one-cycle pulse, end of the long packet payload
//   data_o       packed word, pixel 0 in [7:0] .. pixel 3 in [31:24]
//   adress_out   word address for data_o (bank bit as MSB when ping-pong)
//   rd_bank      bank most recently completed (ping-pong build only)
//   we_o         one-cycle write strobe per word
//   frame_done   one-cycle pulse after a frame closes
//   short_frame  sticky: a frame ended with fewer than V_ACTIVE lines
//   sync_err     sticky: frame_start mid-frame or line_start inside a line
module csi_pixel_packer #(
  parameter int H_ACTIVE = 640,
  parameter int V_ACTIVE = 480,
  parameter int ADDR_W   = 17
) (
  input  logic              sys_clk,
  input  logic              reset,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  input  logic              frame_start,
  input  logic              frame_end,
  input  logic              line_start,
  input  logic              line_end,
  output logic [31:0]       data_o,
`ifdef CSI_PACKER_PINGPONG_EN
  output logic [ADDR_W:0]   adress_out,
  output logic              rd_bank,
`else
  output logic [ADDR_W-1:0] adress_out,
`endif
  output logic              we_o,
  output logic              frame_done,
  output logic              short_frame,
  output logic              sync_err
);

  localparam int COL_W  = $clog2(H_ACTIVE + 1);
  localparam int LINE_W = $clog2(V_ACTIVE + 1);
  localparam int WPL    = H_ACTIVE / 4;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LINE = 2'd1,
    IN_LINE   = 2'd2,
    FLUSH     = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [COL_W-1:0]  col;
  logic [COL_W-1:0]  col_acc;
  logic [LINE_W-1:0] line_cnt;
  logic [LINE_W-1:0] line_cnt_nxt;
  logic [ADDR_W-1:0] line_base;
  logic [23:0]       pack;
  logic              closing;
  logic              closing_nxt;
  logic              line_ok;

  logic take_byte;
  logic wr_full;
  logic wr_flush;
  logic close_line;
  logic open_line;
  logic start_frame;
  logic end_frame;
  logic set_sync;

  logic              vld_p0;
  logic [31:0]       data_p0;
  logic [ADDR_W-1:0] addr_p0;

  logic              vld_p1;
  logic [31:0]       data_p1;
  logic [ADDR_W-1:0] addr_p1;

  // Places a byte into lanes 0..2 of the holding register. Lane 3 is never
  // stored: the 4th byte goes straight into the outgoing word.
  function automatic logic [23:0] lane_insert(input logic [23:0] pk,
                                              input logic [7:0]  b,
                                              input logic [1:0]  lane);
    logic [23:0] r;
    r = pk;
    case (lane)
      2'd0:    r[7:0]   = b;
      2'd1:    r[15:8]  = b;
      2'd2:    r[23:16] = b;
      default: r        = pk;
    endcase
    return r;
  endfunction

  // Line counter saturates at V_ACTIVE so extra lines cannot wrap it back
  // into the writable range.
  function automatic logic [LINE_W-1:0] line_inc_sat(input logic [LINE_W-1:0] n);
    return (n >= LINE_W'(V_ACTIVE)) ? n : n + LINE_W'(1);
  endfunction

  assign line_ok = (line_cnt < LINE_W'(V_ACTIVE));

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    closing_nxt = closing;
    take_byte   = 1'b0;
    wr_full     = 1'b0;
    wr_flush    = 1'b0;
    close_line  = 1'b0;
    open_line   = 1'b0;
    start_frame = 1'b0;
    end_frame   = 1'b0;
    set_sync    = 1'b0;
    col_acc     = col;
    case (state)
      IDLE: begin
        if (frame_start) begin
          start_frame = 1'b1;
          state_nxt   = WAIT_LINE;
        end
      end
      WAIT_LINE: begin
        if (frame_start) begin
          set_sync    = 1'b1;
          start_frame = 1'b1;
        end else if (frame_end) begin
          end_frame = 1'b1;
          state_nxt = IDLE;
        end else if (line_start) begin
          open_line = 1'b1;
          state_nxt = IN_LINE;
        end
      end
      IN_LINE: begin
        if (frame_start) begin
          set_sync    = 1'b1;
          start_frame = 1'b1;
          state_nxt   = WAIT_LINE;
        end else if (line_start) begin
          // Restart the same line; the partial word is discarded.
          set_sync  = 1'b1;
          open_line = 1'b1;
        end else begin
          take_byte = byte_valid && (col < COL_W'(H_ACTIVE));
          if (take_byte) begin
            col_acc = col + COL_W'(1);
          end
          wr_full = take_byte && (col[1:0] == 2'd3) && line_ok;
          // A byte arriving with line_end/frame_end is counted before closing.
          if (line_end || frame_end) begin
            if ((col_acc[1:0] != 2'd0) && (col_acc < COL_W'(H_ACTIVE))) begin
              state_nxt   = FLUSH;
              closing_nxt = frame_end;
            end else begin
              close_line = 1'b1;
              if (frame_end) begin
                end_frame = 1'b1;
                state_nxt = IDLE;
              end else begin
                state_nxt = WAIT_LINE;
              end
            end
          end
        end
      end
      FLUSH: begin
        if (frame_start) begin
          set_sync    = 1'b1;
          start_frame = 1'b1;
          state_nxt   = WAIT_LINE;
        end else begin
          wr_flush   = line_ok;
          close_line = 1'b1;
          if (closing || frame_end) begin
            end_frame = 1'b1;
            state_nxt = IDLE;
          end else if (line_start) begin
            // Line base is advanced by close_line this same cycle.
            open_line = 1'b1;
            state_nxt = IN_LINE;
          end else begin
            state_nxt = WAIT_LINE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    line_cnt_nxt = line_cnt;
    if (start_frame) begin
      line_cnt_nxt = '0;
    end else if (close_line) begin
      line_cnt_nxt = line_inc_sat(line_cnt);
    end
  end

  // Stage p0: word assembly and address generation
  assign vld_p0  = wr_full || wr_flush;
  assign addr_p0 = line_base + ADDR_W'(col >> 2);
  assign data_p0 = wr_full ? {byte_in, pack} : {8'h00, pack};

  always_ff @(posedge sys_clk) begin
    if (reset) begin
      col       <= '0;
      line_cnt  <= '0;
      line_base <= '0;
      pack      <= '0;
      closing   <= 1'b0;
    end else begin
      line_cnt <= line_cnt_nxt;
      closing  <= closing_nxt;

      if (start_frame || open_line) begin
        col <= '0;
      end else begin
        col <= col_acc;
      end

      if (start_frame) begin
        line_base <= '0;
      end else if (close_line && (line_cnt_nxt < LINE_W'(V_ACTIVE))) begin
        line_base <= line_base + ADDR_W'(WPL);
      end

      // Unfilled lanes must read as zero when a partial word is flushed,
      // so the holding register is cleared whenever a word leaves.
      if (start_frame || open_line || wr_flush) begin
        pack <= '0;
      end else if (take_byte) begin
        if (col[1:0] == 2'd3) begin
          pack <= '0;
        end else begin
          pack <= lane_insert(pack, byte_in, col[1:0]);
        end
      end
    end
  end

  // Stage p1: registered write port and status outputs
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      vld_p1      <= 1'b0;
      data_p1     <= '0;
      addr_p1     <= '0;
      frame_done  <= 1'b0;
      short_frame <= 1'b0;
      sync_err    <= 1'b0;
    end else begin
      vld_p1     <= vld_p0;
      frame_done <= end_frame;
      if (vld_p0) begin
        data_p1 <= data_p0;
        addr_p1 <= addr_p0;
      end
      if (end_frame && (line_cnt_nxt < LINE_W'(V_ACTIVE))) begin
        short_frame <= 1'b1;
      end
      if (set_sync) begin
        sync_err <= 1'b1;
      end
    end
  end

  assign data_o = data_p1;
  assign we_o   = vld_p1;

`ifdef CSI_PACKER_PINGPONG_EN
  logic bank;
  logic bank_p1;

  // The bank flips at the same edge that raises frame_done, so a final
  // write issued in the closing cycle still carries the old bank.
  always_ff @(posedge sys_clk) begin
    if (reset) begin
      bank    <= 1'b0;
      rd_bank <= 1'b1;
      bank_p1 <= 1'b0;
    end else begin
      if (vld_p0) begin
        bank_p1 <= bank;
      end
      if (end_frame) begin
        rd_bank <= bank;
        bank    <= ~bank;
      end
    end
  end

  assign adress_out = {bank_p1, addr_p1};
`else
  assign adress_out = addr_p1;
`endif

endmodule

// File: tb/tb_csi_pixel_packer.sv
// Directed testbench for csi_pixel_packer, small geometry: 8 x 2 pixels.
module tb_csi_pixel_packer;

  localparam int H_ACTIVE = 8;
  localparam int V_ACTIVE = 2;
  localparam int ADDR_W   = 3;
`ifdef CSI_PACKER_PINGPONG_EN
  localparam int OUT_AW = ADDR_W + 1;
  logic rd_bank;
`else
  localparam int OUT_AW = ADDR_W;
`endif

  logic              sys_clk = 1'b0;
  logic              reset;
  logic [7:0]        byte_in;
  logic              byte_valid;
  logic              frame_start;
  logic              frame_end;
  logic              line_start;
  logic              line_end;
  logic [31:0]       data_o;
  logic [OUT_AW-1:0] adress_out;
  logic              we_o;
  logic              frame_done;
  logic              short_frame;
  logic              sync_err;

  int checks = 0;
  int errors = 0;

  // Write log filled by the monitor
  logic [ADDR_W-1:0] wa[$];
  logic [31:0]       wd[$];
  logic              wb[$];
  int                fd_cnt = 0;

  always #5 sys_clk = ~sys_clk;

  csi_pixel_packer #(
    .H_ACTIVE(H_ACTIVE),
    .V_ACTIVE(V_ACTIVE),
    .ADDR_W  (ADDR_W)
  ) dut (
    .sys_clk    (sys_clk),
    .reset      (reset),
    .byte_in    (byte_in),
    .byte_valid (byte_valid),
    .frame_start(frame_start),
    .frame_end  (frame_end),
    .line_start (line_start),
    .line_end   (line_end),
    .data_o     (data_o),
    .adress_out (adress_out),
`ifdef CSI_PACKER_PINGPONG_EN
    .rd_bank    (rd_bank),
`endif
    .we_o       (we_o),
    .frame_done (frame_done),
    .short_frame(short_frame),
    .sync_err   (sync_err)
  );

  always @(negedge sys_clk) begin
    if (we_o === 1'b1) begin
      wa.push_back(adress_out[ADDR_W-1:0]);
      wd.push_back(data_o);
`ifdef CSI_PACKER_PINGPONG_EN
      wb.push_back(adress_out[ADDR_W]);
`else
      wb.push_back(1'b0);
`endif
    end
    if (frame_done === 1'b1) fd_cnt++;
  end

  // One clock of stimulus, applied at a falling edge.
  task automatic step(input logic fs, input logic fe, input logic ls,
                      input logic le, input logic bv, input logic [7:0] b);
    frame_start = fs;
    frame_end   = fe;
    line_start  = ls;
    line_end    = le;
    byte_valid  = bv;
    byte_in     = b;
    @(negedge sys_clk);
    frame_start = 1'b0;
    frame_end   = 1'b0;
    line_start  = 1'b0;
    line_end    = 1'b0;
    byte_valid  = 1'b0;
    byte_in     = 8'h00;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 8'h00);
  endtask

  task automatic send_line(input int n, input logic [7:0] first);
    step(0, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 1, first + 8'(i));
    step(0, 0, 0, 1, 0, 8'h00);
    idle(1);
  endtask

  task automatic clear_log();
    wa.delete();
    wd.delete();
    wb.delete();
    fd_cnt = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    // Reset arriving together with the 4th byte of a word must suppress it.
    step(1, 0, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 8'h30 + 8'(i));
    reset = 1'b1;
    step(0, 0, 0, 0, 1, 8'h33);
    checks++;
    if (we_o !== 1'b0) begin errors++; $display("FAIL reset_midline_we: got %b want 0", we_o); end
    idle(1);
    reset = 1'b0;
    checks++;
    if (we_o !== 1'b0) begin errors++; $display("FAIL reset_we: got %b want 0", we_o); end
    checks++;
    if (data_o !== 32'h0) begin errors++; $display("FAIL reset_data: got %h want 0", data_o); end
    checks++;
    if (adress_out !== '0) begin errors++; $display("FAIL reset_addr: got %h want 0", adress_out); end
    checks++;
    if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    checks++;
    if (short_frame !== 1'b0) begin errors++; $display("FAIL reset_short_frame: got %b want 0", short_frame); end
    checks++;
    if (sync_err !== 1'b0) begin errors++; $display("FAIL reset_sync_err: got %b want 0", sync_err); end
`ifdef CSI_PACKER_PINGPONG_EN
    checks++;
    if (rd_bank !== 1'b1) begin errors++; $display("FAIL reset_rd_bank: got %b want 1", rd_bank); end
`endif
    // Unframed bytes after reset must not write.
    clear_log();
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 8'h40 + 8'(i));
    idle(1);
    checks++;
    if (wa.size() != 0) begin errors++; $display("FAIL idle_no_write: got %0d writes want 0", wa.size()); end
  endtask

  task automatic test_full_frame();
    logic [ADDR_W-1:0] ea [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0]       ed [4] = '{32'h03020100, 32'h07060504, 32'h03020100, 32'h07060504};
    clear_log();
    step(1, 0, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 8'(i));
    checks++;
    if (we_o !== 1'b0) begin errors++; $display("FAIL early_we: got %b want 0", we_o); end
    step(0, 0, 0, 0, 1, 8'h03);
    checks++;
    if (we_o !== 1'b1 || adress_out[ADDR_W-1:0] !== 3'd0 || data_o !== 32'h03020100) begin
      errors++;
      $display("FAIL latency_word0: got we=%b addr=%0d data=%h want we=1 addr=0 data=03020100", we_o, adress_out[ADDR_W-1:0], data_o);
    end
    for (int i = 4; i < 8; i++) step(0, 0, 0, 0, 1, 8'(i));
    step(0, 0, 0, 1, 0, 8'h00);
    idle(1);
    send_line(8, 8'h00);
    step(0, 1, 0, 0, 0, 8'h00);
    idle(3);
    checks++;
    if (wa.size() != 4) begin
      errors++;
      $display("FAIL full_count: got %0d writes want 4", wa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
          errors++;
          $display("FAIL full_write%0d: got (%0d,%h) want (%0d,%h)", i, wa[i], wd[i], ea[i], ed[i]);
        end
      end
    end
    checks++;
    if (fd_cnt != 1) begin errors++; $display("FAIL full_frame_done: got %0d pulses want 1", fd_cnt); end
    checks++;
    if (short_frame !== 1'b0) begin errors++; $display("FAIL full_short_frame: got %b want 0", short_frame); end
  endtask

  task automatic test_short_line();
    logic [ADDR_W-1:0] ea [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0]       ed [4] = '{32'hA3A2A1A0, 32'h0000A5A4, 32'h03020100, 32'h07060504};
    clear_log();
    step(1, 0, 0, 0, 0, 8'h00);
    send_line(6, 8'hA0);
    send_line(8, 8'h00);
    step(0, 1, 0, 0, 0, 8'h00);
    idle(3);
    checks++;
    if (wa.size() != 4) begin
      errors++;
      $display("FAIL short_count: got %0d writes want 4", wa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
          errors++;
          $display("FAIL short_write%0d: got (%0d,%h) want (%0d,%h)", i, wa[i], wd[i], ea[i], ed[i]);
        end
      end
    end
  endtask

  task automatic test_overlong();
    logic [ADDR_W-1:0] ea [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0]       ed [4] = '{32'h03020100, 32'h07060504, 32'h13121110, 32'h17161514};
    int n_after_two;
    clear_log();
    step(1, 0, 0, 0, 0, 8'h00);
    send_line(12, 8'h00);
    send_line(12, 8'h10);
    n_after_two = wa.size();
    send_line(12, 8'h20);
    step(0, 1, 0, 0, 0, 8'h00);
    idle(3);
    checks++;
    if (wa.size() != n_after_two) begin
      errors++;
      $display("FAIL line3_no_write: got %0d writes want %0d", wa.size(), n_after_two);
    end
    checks++;
    if (wa.size() != 4) begin
      errors++;
      $display("FAIL overlong_count: got %0d writes want 4", wa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i] || wa[i] >= 3'd4) begin
          errors++;
          $display("FAIL overlong_write%0d: got (%0d,%h) want (%0d,%h)", i, wa[i], wd[i], ea[i], ed[i]);
        end
      end
    end
    checks++;
    if (short_frame !== 1'b0) begin errors++; $display("FAIL overlong_short_frame: got %b want 0", short_frame); end
  endtask

  task automatic test_back_to_back();
    logic [ADDR_W-1:0] ea [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0]       ed [4] = '{32'h13121110, 32'h17161514, 32'h23222120, 32'h00000024};
    clear_log();
    step(1, 0, 0, 0, 0, 8'h00);
    // Last byte of each line arrives together with line_end.
    step(0, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 1, 8'h10 + 8'(i));
    step(0, 0, 0, 1, 1, 8'h17);
    step(0, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 0, 1, 8'h20 + 8'(i));
    step(0, 0, 0, 1, 1, 8'h24);
    idle(1);
    step(0, 1, 0, 0, 0, 8'h00);
    idle(3);
    checks++;
    if (wa.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: got %0d writes want 4", wa.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
          errors++;
          $display("FAIL b2b_write%0d: got (%0d,%h) want (%0d,%h)", i, wa[i], wd[i], ea[i], ed[i]);
        end
      end
    end
    checks++;
    if (sync_err !== 1'b0) begin errors++; $display("FAIL b2b_sync_err: got %b want 0", sync_err); end
  endtask

  task automatic test_resync();
    logic [ADDR_W-1:0] ea [6] = '{3'd0, 3'd1, 3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0]       ed [6] = '{32'h03020100, 32'h07060504, 32'hC3C2C1C0, 32'hC7C6C5C4, 32'hD3D2D1D0, 32'hD7D6D5D4};
    clear_log();
    step(1, 0, 0, 0, 0, 8'h00);
    send_line(8, 8'h00);
    step(0, 0, 1, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 1, 8'hB0 + 8'(i));
    step(1, 0, 0, 0, 0, 8'h00);
    idle(2);
    checks++;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL resync_sync_err: got %b want 1", sync_err); end
    checks++;
    if (wa.size() != 2) begin errors++; $display("FAIL resync_dropped: got %0d writes want 2", wa.size()); end
    send_line(8, 8'hC0);
    send_line(8, 8'hD0);
    step(0, 1, 0, 0, 0, 8'h00);
    idle(3);
    checks++;
    if (wa.size() != 6) begin
      errors++;
      $display("FAIL resync_count: got %0d writes want 6", wa.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks++;
        if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
          errors++;
          $display("FAIL resync_write%0d: got (%0d,%h) want (%0d,%h)", i, wa[i], wd[i], ea[i], ed[i]);
        end
      end
    end
    checks++;
    if (short_frame !== 1'b0) begin errors++; $display("FAIL resync_short_frame: got %b want 0", short_frame); end
  endtask

  task automatic test_early_end();
    clear_log();
    step(1, 0, 0, 0, 0, 8'h00);
    send_line(8, 8'h00);
    step(0, 1, 0, 0, 0, 8'h00);
    idle(3);
    checks++;
    if (fd_cnt != 1) begin errors++; $display("FAIL early_frame_done: got %0d pulses want 1", fd_cnt); end
    checks++;
    if (short_frame !== 1'b1) begin errors++; $display("FAIL early_short_frame: got %b want 1", short_frame); end
    checks++;
    if (sync_err !== 1'b1) begin errors++; $display("FAIL early_sync_sticky: got %b want 1", sync_err); end
    checks++;
    if (wa.size() != 2) begin errors++; $display("FAIL early_count: got %0d writes want 2", wa.size()); end
    do_reset();
    checks++;
    if (short_frame !== 1'b0) begin errors++; $display("FAIL clr_short_frame: got %b want 0", short_frame); end
    checks++;
    if (sync_err !== 1'b0) begin errors++; $display("FAIL clr_sync_err: got %b want 0", sync_err); end
  endtask

`ifdef CSI_PACKER_PINGPONG_EN
  task automatic test_pingpong();
    do_reset();
    checks++;
    if (rd_bank !== 1'b1) begin errors++; $display("FAIL pp_rd_bank_reset: got %b want 1", rd_bank); end
    for (int f = 0; f < 2; f++) begin
      clear_log();
      step(1, 0, 0, 0, 0, 8'h00);
      send_line(8, 8'h00);
      send_line(8, 8'h00);
      step(0, 1, 0, 0, 0, 8'h00);
      idle(3);
      checks++;
      if (wa.size() != 4) begin
        errors++;
        $display("FAIL pp_count%0d: got %0d writes want 4", f, wa.size());
      end else begin
        for (int i = 0; i < 4; i++) begin
          checks++;
          if (wb[i] !== 1'(f)) begin
            errors++;
            $display("FAIL pp_bank_f%0d_w%0d: got %b want %0d", f, i, wb[i], f);
          end
        end
      end
      checks++;
      if (rd_bank !== 1'(f)) begin errors++; $display("FAIL pp_rd_bank_f%0d: got %b want %0d", f, rd_bank, f); end
    end
  endtask
`endif

  initial begin
    reset       = 1'b1;
    byte_in     = 8'h00;
    byte_valid  = 1'b0;
    frame_start = 1'b0;
    frame_end   = 1'b0;
    line_start  = 1'b0;
    line_end    = 1'b0;
    @(negedge sys_clk);
    test_reset();
    test_full_frame();
    test_short_line();
    test_overlong();
    test_back_to_back();
    test_resync();
    test_early_end();
`ifdef CSI_PACKER_PINGPONG_EN
    test_pingpong();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1);
  end

endmodule

// File: doc/csi_pixel_packer.md
Name: csi_pixel_packer

Overview:
- Sits between the MIPI CSI-2 receiver's payload byte output and port A of the dual-clock frame RAM.
- Takes RAW8 payload bytes plus frame/line markers and packs 4 consecutive pixels into one 32-bit word.
- Generates the word write address and the write strobe.
- Crops to the active window, pads short lines and flags framing errors, so the display side can read pixel N at word N>>2, byte lane N[1:0].

Parameters:
- H_ACTIVE, 640, pixels stored per line; must be a multiple of 4.
- V_ACTIVE, 480, lines stored per frame.
- ADDR_W, 17, word address width; must satisfy 2^ADDR_W >= H_ACTIVE*V_ACTIVE/4.

Ports:
- sys_clk  in  1  single clock for all logic (receiver byte-domain clock).
- reset  in  1  synchronous, active-high reset.
- byte_in  in  8  payload pixel byte.
- byte_valid  in  1  byte_in is valid this cycle.
- frame_start  in  1  one-cycle pulse, Frame Start short packet.
- frame_end  in  1  one-cycle pulse, Frame End short packet.
- line_start  in  1  one-cycle pulse, start of a long packet.
- line_end  in  1  one-cycle pulse, end of the long packet payload.
- data_o  out  32  packed word; pixel 0 in [7:0], pixel 3 in [31:24].
- adress_out  out  ADDR_W  word address for data_o.
- we_o  out  1  write strobe for data_o/adress_out, one cycle per word.
- frame_done  out  1  one-cycle pulse after a frame closes.
- short_frame  out  1  sticky; frame ended with fewer than V_ACTIVE lines.
- sync_err  out  1  sticky; frame_start received mid-frame, or line_start received inside a line.

Behaviour:
- Reset: state=IDLE. data_o=0, adress_out=0, we_o=0, frame_done=0, short_frame=0, sync_err=0. Byte counter, line counter and packing register cleared.
- States:
  - IDLE: wait for frame_start.
  - WAIT_LINE: between lines.
  - IN_LINE: accepting bytes.
  - FLUSH: write the padded partial word, one cycle.
- IDLE -> WAIT_LINE on frame_start. Line counter = 0. Sticky flags are NOT cleared here; they clear only on reset.
- WAIT_LINE -> IN_LINE on line_start. Column counter = 0; line base address = line*H_ACTIVE/4.
- IN_LINE, on byte_valid:
  - While column < H_ACTIVE, the byte goes into lane column[1:0] and column increments.
  - On the 4th byte (column[1:0]==3), the registered outputs update next cycle: data_o = packed word, adress_out = base + column>>2, we_o=1 for exactly one cycle. Latency is 1 cycle from the 4th byte.
  - Bytes with column >= H_ACTIVE are dropped and produce no write.
- IN_LINE, on line_end:
  - If column[1:0] != 0 and column < H_ACTIVE: go to FLUSH. Write the partial word with the unfilled lanes set to 0x00, then go to WAIT_LINE.
  - Otherwise go directly to WAIT_LINE.
  - Line counter increments in either case.
  - Missing words of a short line are not written; RAM keeps its old contents.
- byte_valid and line_end in the same cycle: the byte is accepted first, then the line closes.
- Lines with line counter >= V_ACTIVE: handled as normal in the state machine, but no writes are issued.
- frame_end in WAIT_LINE or IN_LINE:
  - Any pending partial word is flushed first, as for line_end.
  - Then go to IDLE and pulse frame_done one cycle later.
  - If line counter < V_ACTIVE at that point, set short_frame.
- frame_start while not in IDLE: set sync_err, abandon any partial word (no write), restart at WAIT_LINE with line counter 0.
- line_start while in IN_LINE: set sync_err and restart the line at column 0; the partial word is dropped.
- we_o is never asserted in IDLE. adress_out never reaches H_ACTIVE*V_ACTIVE/4 or above.
- Reset mid-line: everything returns to reset values in the next cycle; no write is issued.

Optional Feature:
- Macro: CSI_PACKER_PINGPONG_EN.
- When defined:
  - adress_out is ADDR_W+1 bits wide; the MSB is a bank bit.
  - The bank bit toggles on every frame_done.
  - An extra output, rd_bank (1 bit), equals the bank most recently completed, so the reader always displays a full frame.
  - Reset sets bank=0 and rd_bank=1.
- When undefined: a single buffer, adress_out is ADDR_W bits and rd_bank does not exist.

Test Plan:
- Full frame, small config: H_ACTIVE=8, V_ACTIVE=2. Sequence frame_start, then per line: line_start, bytes 0x00..0x07, line_end; then frame_end. Required: 4 writes, (addr,data) = (0,0x03020100), (1,0x07060504), (2,0x03020100), (3,0x07060504). frame_done pulses once. short_frame=0.
- Short line: 6 bytes 0xA0..0xA5, then line_end. Required: write (0,0xA3A2A1A0), then FLUSH write (1,0x0000A5A4). The next line starts at addr 2.
- Overlong line and extra line: 12 bytes per line and 3 lines with V_ACTIVE=2. Required: only 4 writes in total, no address >= 4, no write during line 3.
- Mid-frame resync: frame_start after 1 line plus 3 bytes. Required: sync_err=1, no write for the 3 bytes, next line writes at addr 0.
- Early frame_end after 1 line. Required: frame_done pulses, short_frame=1. Reset clears short_frame and sync_err to 0.
- With CSI_PACKER_PINGPONG_EN: two full frames. Required: frame 1 writes with bank bit 0, frame 2 with bank bit 1. rd_bank=1 after reset, 0 after frame 1, 1 after frame 2.
